// File: rtl/line_cache_master.sv
// Direct-mapped line cache: word-wide processor port in front of a 128-bit line memory.
// Write-back by default; define LINE_CACHE_WRITE_THROUGH_EN for write-through operation.
module line_cache_master #(
    parameter int NUM_LINES = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         proc_read,
    input  logic         proc_write,
    input  logic [29:0]  proc_addr,
    input  logic [31:0]  proc_wdata,
    output logic [31:0]  proc_rdata,
    output logic         proc_stall,
    output logic         mem_read,
    output logic         mem_write,
    output logic [27:0]  mem_addr,
    output logic [127:0] mem_wdata,
    input  logic [127:0] mem_rdata,
    input  logic         mem_ready
);
    localparam int IDX_W = $clog2(NUM_LINES);
    localparam int TAG_W = 28 - IDX_W;

    typedef enum logic [1:0] {IDLE, WRITEBACK, ALLOCATE} state_t;

    state_t               r_state;
    state_t               w_next;

    logic [NUM_LINES-1:0] r_valid;
    logic [TAG_W-1:0]     r_tag  [NUM_LINES];
    logic [127:0]         r_data [NUM_LINES];
    logic                 r_gap;
`ifdef LINE_CACHE_WRITE_THROUGH_EN
    logic                 r_wt_done;
`else
    logic [NUM_LINES-1:0] r_dirty;
`endif

    logic [1:0]           w_word;
    logic [IDX_W-1:0]     w_idx;
    logic [TAG_W-1:0]     w_tag;
    logic                 w_hit;
    logic                 w_req;
    logic [127:0]         w_line;
    logic                 w_wr_word;
    logic                 w_wb_done;
    logic                 w_alloc_done;

    assign w_word     = proc_addr[1:0];
    assign w_idx      = proc_addr[IDX_W+1:2];
    assign w_tag      = proc_addr[29:IDX_W+2];
    assign w_req      = proc_read | proc_write;
    assign w_hit      = r_valid[w_idx] && (r_tag[w_idx] == w_tag);
    assign w_line     = r_data[w_idx];
    assign proc_rdata = w_line[{w_word, 5'd0} +: 32];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
            r_valid <= '0;
            r_gap   <= 1'b0;
`ifdef LINE_CACHE_WRITE_THROUGH_EN
            r_wt_done <= 1'b0;
`else
            r_dirty <= '0;
`endif
        end else begin
            r_state <= w_next;
            r_gap   <= w_wb_done;
            if (w_alloc_done) begin
                r_valid[w_idx] <= 1'b1;
            end
`ifdef LINE_CACHE_WRITE_THROUGH_EN
            r_wt_done <= w_wb_done;
`else
            if (w_wr_word) begin
                r_dirty[w_idx] <= 1'b1;
            end
            if (w_wb_done || w_alloc_done) begin
                r_dirty[w_idx] <= 1'b0;
            end
`endif
        end
    end

    // Line storage is not reset; valid bits alone qualify its contents.
    always_ff @(posedge clk) begin
        if (w_alloc_done) begin
            r_data[w_idx] <= mem_rdata;
            r_tag[w_idx]  <= w_tag;
        end else if (w_wr_word) begin
            r_data[w_idx][{w_word, 5'd0} +: 32] <= proc_wdata;
        end
    end

    always_comb begin
        w_next       = r_state;
        proc_stall   = 1'b0;
        mem_read     = 1'b0;
        mem_write    = 1'b0;
        mem_addr     = '0;
        mem_wdata    = '0;
        w_wr_word    = 1'b0;
        w_wb_done    = 1'b0;
        w_alloc_done = 1'b0;
        case (r_state)
            IDLE: begin
                if (w_req) begin
                    if (w_hit) begin
`ifdef LINE_CACHE_WRITE_THROUGH_EN
                        // A write completes only on the IDLE cycle right after its line was pushed out.
                        if (proc_write && !r_wt_done) begin
                            w_wr_word  = 1'b1;
                            proc_stall = 1'b1;
                            w_next     = WRITEBACK;
                        end
`else
                        w_wr_word = proc_write;
`endif
                    end else begin
                        proc_stall = 1'b1;
`ifdef LINE_CACHE_WRITE_THROUGH_EN
                        w_next = ALLOCATE;
`else
                        w_next = r_dirty[w_idx] ? WRITEBACK : ALLOCATE;
`endif
                    end
                end
            end
            WRITEBACK: begin
                proc_stall = 1'b1;
                mem_write  = 1'b1;
                mem_addr   = {r_tag[w_idx], w_idx};
                mem_wdata  = w_line;
                if (mem_ready) begin
                    w_wb_done = 1'b1;
`ifdef LINE_CACHE_WRITE_THROUGH_EN
                    w_next = IDLE;
`else
                    w_next = ALLOCATE;
`endif
                end
            end
            ALLOCATE: begin
                proc_stall = 1'b1;
                // r_gap holds mem_read low for one cycle after a write-back completes.
                if (!r_gap) begin
                    mem_read = 1'b1;
                    mem_addr = {w_tag, w_idx};
                    if (mem_ready) begin
                        w_alloc_done = 1'b1;
                        w_next       = IDLE;
                    end
                end
            end
            default: w_next = IDLE;
        endcase
    end

endmodule

// File: tb/tb_line_cache_master.sv
// Directed bench for line_cache_master (default write-back build, NUM_LINES=8).
module tb_line_cache_master;
    logic         clk = 1'b0;
    logic         rst_n;
    logic         proc_read, proc_write;
    logic [29:0]  proc_addr;
    logic [31:0]  proc_wdata;
    logic [31:0]  proc_rdata;
    logic         proc_stall;
    logic         mem_read, mem_write;
    logic [27:0]  mem_addr;
    logic [127:0] mem_wdata;
    logic [127:0] mem_rdata;
    logic         mem_ready;

    int checks   = 0;
    int failures = 0;
    int rd_starts = 0;
    logic prev_rd = 1'b0;

    line_cache_master #(.NUM_LINES(8)) dut (
        .clk(clk), .rst_n(rst_n),
        .proc_read(proc_read), .proc_write(proc_write),
        .proc_addr(proc_addr), .proc_wdata(proc_wdata),
        .proc_rdata(proc_rdata), .proc_stall(proc_stall),
        .mem_read(mem_read), .mem_write(mem_write),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata), .mem_ready(mem_ready)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (mem_read && !prev_rd) rd_starts++;
        prev_rd = mem_read;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: bench did not finish");
        $fatal(1, "watchdog");
    end

    typedef struct {
        logic        rd;
        logic        wr;
        logic [29:0] addr;
        logic [31:0] wdata;
        logic        ready;
        logic        exp_stall;
        logic [31:0] exp_rdata;
    } vec_t;

    localparam int NV = 11;
    vec_t vecs [NV];

    localparam logic [127:0] LINE1 = {32'h33333333, 32'h22222222, 32'h11111111, 32'hDEADBEEF};
    localparam logic [127:0] LINE2 = {32'hB3B3B3B3, 32'hB2B2B2B2, 32'hB1B1B1B1, 32'hB0B0B0B0};
    localparam logic [127:0] LINE3 = {32'hC3C3C3C3, 32'hC2C2C2C2, 32'hC1C1C1C1, 32'hC0C0C0C0};
    localparam logic [127:0] LINE4 = {32'hD3D3D3D3, 32'hD2D2D2D2, 32'hD1D1D1D1, 32'hD0D0D0D0};
    localparam logic [127:0] LINE5 = {32'hE3E3E3E3, 32'hE2E2E2E2, 32'hE1E1E1E1, 32'hE0E0E0E0};
    localparam logic [127:0] LINE6 = {32'hF3F3F3F3, 32'hF2F2F2F2, 32'hF1F1F1F1, 32'hF0F0F0F0};

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic req(input logic rd, input logic wr, input logic [29:0] a, input logic [31:0] d);
        @(negedge clk);
        proc_read  = rd;
        proc_write = wr;
        proc_addr  = a;
        proc_wdata = d;
        #1;
    endtask

    // Waits for the requested transfer, checks it is held for 'delay' cycles, then pulses mem_ready.
    task automatic serve(input bit is_wr, input int delay, input logic [127:0] rdata,
                         input logic [27:0] exp_addr, input logic [127:0] exp_wdata,
                         input string nm);
        int n = 0;
        while (((is_wr ? mem_write : mem_read) !== 1'b1) && n < 20) begin
            @(negedge clk);
            #1;
            n++;
        end
        chk({nm, "_start"}, n < 20, 1);
        chk({nm, "_addr"}, mem_addr, exp_addr);
        if (is_wr) chk({nm, "_wdata"}, mem_wdata, exp_wdata);
        chk({nm, "_excl"}, is_wr ? mem_read : mem_write, 0);
        for (int i = 0; i < delay; i++) begin
            @(negedge clk);
            #1;
            chk({nm, "_hold"}, {mem_read, mem_write, proc_stall, mem_addr},
                {~is_wr, is_wr, 1'b1, exp_addr});
        end
        @(negedge clk);
        mem_rdata = rdata;
        mem_ready = 1'b1;
        #1;
        chk({nm, "_stall_rdy"}, proc_stall, 1);
        @(negedge clk);
        mem_ready = 1'b0;
        #1;
        chk({nm, "_drop"}, {mem_read, mem_write}, 2'b00);
    endtask

    initial begin
        int s0;
        vecs[0]  = '{1'b1, 1'b0, 30'h10, 32'h0,        1'b0, 1'b0, 32'hDEADBEEF};
        vecs[1]  = '{1'b1, 1'b0, 30'h11, 32'h0,        1'b0, 1'b0, 32'h11111111};
        vecs[2]  = '{1'b1, 1'b0, 30'h12, 32'h0,        1'b0, 1'b0, 32'h22222222};
        vecs[3]  = '{1'b1, 1'b0, 30'h13, 32'h0,        1'b0, 1'b0, 32'h33333333};
        vecs[4]  = '{1'b0, 1'b0, 30'h30, 32'h0,        1'b1, 1'b0, 32'h0};
        vecs[5]  = '{1'b0, 1'b1, 30'h12, 32'hA5A5A5A5, 1'b0, 1'b0, 32'h0};
        vecs[6]  = '{1'b1, 1'b0, 30'h12, 32'h0,        1'b0, 1'b0, 32'hA5A5A5A5};
        vecs[7]  = '{1'b1, 1'b0, 30'h13, 32'h0,        1'b0, 1'b0, 32'h33333333};
        vecs[8]  = '{1'b0, 1'b1, 30'h10, 32'h12345678, 1'b0, 1'b0, 32'h0};
        vecs[9]  = '{1'b1, 1'b0, 30'h10, 32'h0,        1'b0, 1'b0, 32'h12345678};
        vecs[10] = '{1'b1, 1'b0, 30'h11, 32'h0,        1'b0, 1'b0, 32'h11111111};

        rst_n = 1'b0;
        proc_read = 1'b0; proc_write = 1'b0; proc_addr = '0; proc_wdata = '0;
        mem_rdata = '0; mem_ready = 1'b0;
        #2;
        chk("reset_outputs", {mem_read, mem_write, mem_addr, proc_stall}, '0);
        chk("reset_wdata", mem_wdata, '0);
        @(negedge clk);
        rst_n = 1'b1;

        // Cold miss fill
        req(1'b1, 1'b0, 30'h10, 32'h0);
        chk("miss_stall", {proc_stall, mem_read, mem_write}, 3'b100);
        serve(1'b0, 0, LINE1, 28'h4, '0, "fill1");
        chk("fill1_stall", proc_stall, 0);
        chk("fill1_rdata", proc_rdata, 32'hDEADBEEF);

        // Single-cycle hits, writes and a stray mem_ready
        for (int i = 0; i < NV; i++) begin
            @(negedge clk);
            proc_read  = vecs[i].rd;
            proc_write = vecs[i].wr;
            proc_addr  = vecs[i].addr;
            proc_wdata = vecs[i].wdata;
            mem_ready  = vecs[i].ready;
            #1;
            chk($sformatf("vec%0d_stall", i), proc_stall, vecs[i].exp_stall);
            chk($sformatf("vec%0d_traffic", i), {mem_read, mem_write}, 2'b00);
            if (vecs[i].rd) chk($sformatf("vec%0d_rdata", i), proc_rdata, vecs[i].exp_rdata);
        end
        mem_ready = 1'b0;

        // Dirty conflict miss: write-back then slow allocate
        req(1'b1, 1'b0, 30'h30, 32'h0);
        chk("conflict_stall", {proc_stall, mem_read, mem_write}, 3'b100);
        serve(1'b1, 0, '0, 28'h4,
              {32'h33333333, 32'hA5A5A5A5, 32'h11111111, 32'h12345678}, "wb1");
        s0 = rd_starts;
        serve(1'b0, 10, LINE2, 28'hC, '0, "fill2");
        chk("fill2_single", rd_starts - s0, 1);
        chk("fill2_rdata", {proc_stall, proc_rdata}, {1'b0, 32'hB0B0B0B0});

        // Reset during allocate aborts the fill and invalidates everything
        req(1'b1, 1'b0, 30'h50, 32'h0);
        @(negedge clk);
        #1;
        chk("alloc_active", {mem_read, mem_addr}, {1'b1, 28'h14});
        rst_n = 1'b0;
        #1;
        chk("rst_abort", {mem_read, mem_write, mem_addr}, '0);
        rst_n = 1'b1;
        #1;
        chk("rst_remiss", proc_stall, 1);
        serve(1'b0, 0, LINE3, 28'h14, '0, "fill3");
        chk("fill3_rdata", {proc_stall, proc_rdata}, {1'b0, 32'hC0C0C0C0});
        req(1'b1, 1'b0, 30'h30, 32'h0);
        chk("rst_inval_miss", proc_stall, 1);
        serve(1'b0, 0, LINE4, 28'hC, '0, "fill4");
        chk("fill4_rdata", proc_rdata, 32'hD0D0D0D0);

        // Write miss on clean line: allocate, then the write merges
        req(1'b0, 1'b1, 30'h71, 32'hCAFEF00D);
        chk("wmiss_stall", {proc_stall, mem_write}, 2'b10);
        serve(1'b0, 0, LINE5, 28'h1C, '0, "fill5");
        chk("wmerge_stall", proc_stall, 0);
        req(1'b1, 1'b0, 30'h71, 32'h0);
        chk("wmerge_rdata", {proc_stall, proc_rdata}, {1'b0, 32'hCAFEF00D});
        req(1'b1, 1'b0, 30'h70, 32'h0);
        chk("wmerge_w0", proc_rdata, 32'hE0E0E0E0);

        // Merged write left the line dirty
        req(1'b1, 1'b0, 30'h10, 32'h0);
        serve(1'b1, 2, '0, 28'h1C,
              {32'hE3E3E3E3, 32'hE2E2E2E2, 32'hCAFEF00D, 32'hE0E0E0E0}, "wb2");
        serve(1'b0, 0, LINE6, 28'h4, '0, "fill6");
        chk("fill6_rdata", {proc_stall, proc_rdata}, {1'b0, 32'hF0F0F0F0});

        req(1'b0, 1'b0, 30'h0, 32'h0);
        chk("idle_quiet", {proc_stall, mem_read, mem_write}, 3'b000);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
